// File: rtl/bus_requester.sv
// Master-side bus requester: takes one client burst, arbitrates for the shared
// bus, issues one beat per granted cycle and returns read data in issue order.
module bus_requester #(
   parameter int GRANT_BIT = 0,
   parameter int ARB_W     = 3,
   parameter int ADDR_W    = 24,
   parameter int CMD_W     = 3,
   parameter int DATA_W    = 32,
   parameter int READ_LAT  = 2,
   parameter int TIMEOUT   = 255
) (
   input  logic              clk0,
   input  logic              reset,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [CMD_W-1:0]  req_cmd_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [2:0]        req_len_i,
   input  logic              wd_valid_i,
   output logic              wd_ready_o,
   input  logic [DATA_W-1:0] wd_data_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              done_o,
   output logic              err_o,
   output logic [ARB_W-1:0]  bus_request_o,
   input  logic [ARB_W-1:0]  bus_grant_i,
   output logic [ADDR_W-1:0] mst_addr_o,
   output logic [CMD_W-1:0]  mst_cmd_o,
   output logic [DATA_W-1:0] mst_dataout_o,
   input  logic [DATA_W-1:0] mst_datain_i
);

   localparam logic [CMD_W-1:0] CMD_NOP   = '0;
   localparam logic [CMD_W-1:0] CMD_READ  = CMD_W'(1);
   localparam logic [CMD_W-1:0] CMD_WRITE = CMD_W'(2);
   localparam logic [ARB_W-1:0] GNT_MASK  = ARB_W'(1) << GRANT_BIT;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_DRAIN, S_RELEASE} state_t;

   state_t              state_q;
   logic [CMD_W-1:0]    cmd_q;
   logic [ADDR_W-1:0]   base_q;
   logic [2:0]          len_q;
   logic [2:0]          idx_q;
   logic                last_q;
   logic [7:0]          wait_q;
   logic [READ_LAT-1:0] sr_q;
   logic                req_ready_q;
   logic                bus_req_q;
   logic                done_q;
   logic                err_q;
   logic [ADDR_W-1:0]   mst_addr_q;
   logic [CMD_W-1:0]    mst_cmd_q;
   logic [DATA_W-1:0]   mst_dout_q;

   logic                gnt;
   logic                is_rd;
   logic                issue;
   logic [ADDR_W-1:0]   beat_addr;
   logic [READ_LAT-1:0] sr_d;
   logic [READ_LAT-1:0] sr_lo;

   assign gnt       = |(bus_grant_i & GNT_MASK);
   assign is_rd     = (cmd_q == CMD_READ);
   // A beat is taken in the cycle grant is seen, so it shows on the bus next cycle.
   assign issue     = (state_q == S_REQ || (state_q == S_XFER && !last_q)) &&
                      gnt && (is_rd || wd_valid_i);
   assign beat_addr = base_q + ADDR_W'(idx_q);
   assign sr_d      = (sr_q << 1) | READ_LAT'(mst_cmd_q == CMD_READ);
   assign sr_lo     = sr_q << 1;

   assign req_ready_o   = req_ready_q;
   assign wd_ready_o    = issue && !is_rd;
   assign rsp_valid_o   = sr_q[READ_LAT-1];
   assign rsp_data_o    = rsp_valid_o ? mst_datain_i : '0;
   assign done_o        = done_q;
   assign err_o         = err_q;
   assign bus_request_o = bus_req_q ? GNT_MASK : '0;
   assign mst_addr_o    = mst_addr_q;
   assign mst_cmd_o     = mst_cmd_q;
   assign mst_dataout_o = mst_dout_q;

   always_ff @(posedge clk0 or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cmd_q       <= CMD_NOP;
         base_q      <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         last_q      <= 1'b0;
         wait_q      <= '0;
         sr_q        <= '0;
         req_ready_q <= 1'b0;
         bus_req_q   <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         mst_addr_q  <= '0;
         mst_cmd_q   <= CMD_NOP;
         mst_dout_q  <= '0;
      end else begin
         sr_q       <= sr_d;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         mst_cmd_q  <= CMD_NOP;
         mst_addr_q <= '0;
         mst_dout_q <= '0;
         if (issue) begin
            mst_cmd_q  <= cmd_q;
            mst_addr_q <= beat_addr;
            mst_dout_q <= is_rd ? '0 : wd_data_i;
            if (idx_q == len_q) last_q <= 1'b1;
            else                idx_q  <= idx_q + 3'd1;
         end
         case (state_q)
            S_IDLE: begin
               req_ready_q <= 1'b1;
               if (req_ready_q && req_valid_i &&
                   (req_cmd_i == CMD_READ || req_cmd_i == CMD_WRITE)) begin
                  cmd_q       <= req_cmd_i;
                  base_q      <= req_addr_i;
                  len_q       <= req_len_i;
                  idx_q       <= '0;
                  last_q      <= 1'b0;
                  wait_q      <= '0;
                  req_ready_q <= 1'b0;
                  bus_req_q   <= 1'b1;
                  state_q     <= S_REQ;
               end
            end
            S_REQ: begin
               if (gnt) begin
                  state_q <= S_XFER;
               end else if (wait_q == 8'(TIMEOUT - 1)) begin
                  err_q       <= 1'b1;
                  bus_req_q   <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
            end
            S_XFER: begin
               if (last_q) begin
                  if (is_rd) begin
                     state_q <= S_DRAIN;
                  end else begin
                     bus_req_q <= 1'b0;
                     done_q    <= 1'b1;
                     state_q   <= S_RELEASE;
                  end
               end else if (!gnt) begin
                  wait_q  <= '0;
                  state_q <= S_REQ;
               end
            end
            S_DRAIN: begin
               // Only the beat maturing this cycle is left in flight.
               if (sr_lo == '0) begin
                  bus_req_q <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               req_ready_q <= 1'b1;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_requester.sv
// Bench for bus_requester: table of bursts with grant/stall schedules, a
// scoreboard for bus beats and read responses, plus timeout and reset cases.
module tb_bus_requester;
   localparam int GB = 0;
   localparam int RL = 2;
   localparam int TO = 255;
   localparam logic [2:0] NOP = 3'd0, RD = 3'd1, WR = 3'd2;
   localparam logic [2:0] GMASK = 3'(1 << GB);

   logic        clk0 = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0, wd_valid = 1'b0;
   logic [2:0]  req_cmd = '0, req_len = '0, bus_grant = '0;
   logic [23:0] req_addr = '0;
   logic [31:0] wd_data = '0, mst_datain = '1;
   logic        req_ready, wd_ready, rsp_valid, done, err;
   logic [31:0] rsp_data, mst_dataout;
   logic [2:0]  bus_request, mst_cmd;
   logic [23:0] mst_addr;

   always #5 clk0 = ~clk0;

   bus_requester #(.GRANT_BIT(GB), .ARB_W(3), .ADDR_W(24), .CMD_W(3), .DATA_W(32),
                   .READ_LAT(RL), .TIMEOUT(TO)) dut (
      .clk0(clk0), .reset(reset),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_cmd_i(req_cmd),
      .req_addr_i(req_addr), .req_len_i(req_len),
      .wd_valid_i(wd_valid), .wd_ready_o(wd_ready), .wd_data_i(wd_data),
      .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
      .done_o(done), .err_o(err),
      .bus_request_o(bus_request), .bus_grant_i(bus_grant),
      .mst_addr_o(mst_addr), .mst_cmd_o(mst_cmd), .mst_dataout_o(mst_dataout),
      .mst_datain_i(mst_datain));

   int ntot = 0, npass = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [31:0] rdat(input logic [23:0] a);
      return {8'hD0, a};
   endfunction

   function automatic logic [127:0] outs();
      return 128'({req_ready, wd_ready, rsp_valid, rsp_data, done, err,
                   bus_request, mst_addr, mst_cmd, mst_dataout});
   endfunction

   typedef struct packed {logic [2:0] cmd; logic [23:0] addr; logic [31:0] data;} beat_t;
   typedef struct {int due; logic [31:0] d;} pend_t;
   typedef struct {
      logic [2:0] cmd; logic [23:0] addr; logic [2:0] len;
      int gd, drop, gap, sat, stall, lat;
   } txn_t;

   beat_t       exp_beat[$];
   logic [31:0] exp_rsp[$];
   pend_t       pend[$];
   beat_t       eb;
   int          cyc = 0;

   // SDRAM model: read data shows up READ_LAT cycles after the READ beat.
   always @(posedge clk0) begin
      cyc++;
      #1;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         mst_datain = pend[0].d;
         void'(pend.pop_front());
      end else begin
         mst_datain = '1;
      end
   end

   always @(negedge clk0) begin
      if (!reset) begin
         if (mst_cmd != NOP) begin
            if (mst_cmd == RD) pend.push_back('{cyc + RL, rdat(mst_addr)});
            if (exp_beat.size() == 0) begin
               chk("beat_extra", 128'({mst_cmd, mst_addr, mst_dataout}), 128'(0));
            end else begin
               eb = exp_beat.pop_front();
               chk("beat", 128'({mst_cmd, mst_addr, mst_dataout}), 128'(eb));
            end
         end else begin
            chk("nop_bus", 128'({mst_addr, mst_dataout}), 128'(0));
         end
         if (rsp_valid) begin
            if (exp_rsp.size() == 0) chk("rsp_extra", 128'({1'b1, rsp_data}), 128'(0));
            else chk("rsp", 128'(rsp_data), 128'(exp_rsp.pop_front()));
         end
      end
   end

   task automatic run_txn(input txn_t t, input int rst_at, output int rsp_left);
      logic [31:0] wd [8];
      beat_t b;
      logic  g;
      int lat = -1, beats = 0, wrc = 0, wi = 0, fb = -1, fr = -1, blow = 0, errs = 0;
      int n = int'(t.len) + 1;
      rsp_left = -1;
      for (int i = 0; i < 8; i++) wd[i] = {16'hC0DE, t.addr[7:0], 8'(i)};
      for (int i = 0; i < n; i++) begin
         b.cmd  = t.cmd;
         b.addr = t.addr + 24'(i);
         b.data = (t.cmd == WR) ? wd[i] : 32'h0;
         exp_beat.push_back(b);
         if (t.cmd == RD) exp_rsp.push_back(rdat(t.addr + 24'(i)));
      end
      @(posedge clk0); #1;
      req_valid = 1'b1; req_cmd = t.cmd; req_addr = t.addr; req_len = t.len;
      @(negedge clk0);
      chk("accept_rdy", 128'(req_ready), 128'(1));
      @(posedge clk0); #1;
      req_valid = 1'b0;
      for (int k = 0; k < 600; k++) begin
         g = (k >= t.gd) && !(t.drop >= 0 && k >= t.gd + t.drop && k < t.gd + t.drop + t.gap);
         bus_grant = g ? GMASK : ~GMASK;
         wd_valid  = (t.cmd == WR) &&
                     !(t.stall > 0 && k >= t.gd + t.sat && k < t.gd + t.sat + t.stall);
         wd_data   = wd[(wi > 7) ? 7 : wi];
         if (k == rst_at) begin
            reset = 1'b1;
            #1;
            chk("rst_outs_mid", outs(), 128'(0));
            rsp_left = exp_rsp.size() + 100 * exp_beat.size();
            exp_rsp.delete(); exp_beat.delete(); pend.delete();
            bus_grant = '0; wd_valid = 1'b0;
            return;
         end
         @(negedge clk0);
         if (mst_cmd != NOP) begin beats++; if (fb < 0) fb = k; end
         if (rsp_valid && fr < 0) fr = k;
         if (wd_ready) begin wrc++; wi++; end
         if (err) errs++;
         if (done) begin lat = k; break; end
         if (bus_request != GMASK) blow++;
         @(posedge clk0); #1;
      end
      chk("done_lat", 128'(lat), 128'(t.lat));
      chk("breq_hold", 128'(blow), 128'(0));
      chk("breq_rel", 128'(bus_request), 128'(0));
      chk("err_none", 128'(errs), 128'(0));
      chk("beats", 128'(beats), 128'(n));
      chk("wd_cnt", 128'(wrc), 128'((t.cmd == WR) ? n : 0));
      if (t.cmd == RD) chk("rsp_lat", 128'(fr - fb), 128'(RL));
      chk("sb_empty", 128'(exp_beat.size() + exp_rsp.size()), 128'(0));
      @(posedge clk0); #1;
      bus_grant = '0; wd_valid = 1'b0;
      @(negedge clk0);
      chk("done_pulse", 128'({done, req_ready}), 128'(2'b01));
   endtask

   txn_t tbl [6];
   txn_t rt;
   int   left, ek, tb_beats, dn, rv;

   initial begin
      //          cmd addr          len   gd drop gap sat stall lat
      tbl[0] = '{WR, 24'h000100, 3'd3, 2, -1, 0, 0, 0, 7};
      tbl[1] = '{RD, 24'hFFFFFE, 3'd7, 1, -1, 0, 0, 0, 12};
      tbl[2] = '{RD, 24'h002000, 3'd5, 0,  2, 3, 0, 0, 12};
      tbl[3] = '{WR, 24'h003000, 3'd4, 0, -1, 0, 2, 2, 8};
      tbl[4] = '{RD, 24'hABCDEF, 3'd0, 3, -1, 0, 0, 0, 7};
      tbl[5] = '{WR, 24'h7FFFF8, 3'd7, 0, -1, 0, 0, 0, 9};

      repeat (2) @(negedge clk0);
      chk("rst_outs", outs(), 128'(0));
      @(posedge clk0); #1;
      reset = 1'b0;
      @(negedge clk0);
      chk("rdy_first", 128'(req_ready), 128'(0));
      @(negedge clk0);
      chk("rdy_after", 128'(req_ready), 128'(1));

      @(posedge clk0); #1;
      req_valid = 1'b1; req_cmd = 3'h3; req_addr = 24'h55; req_len = 3'd1;
      @(posedge clk0); #1;
      req_valid = 1'b0;
      @(negedge clk0);
      chk("bad_cmd", 128'({bus_request, req_ready}), 128'({3'b000, 1'b1}));

      for (int i = 0; i < 6; i++) run_txn(tbl[i], -1, left);

      // Grant never arrives: the request must time out.
      @(posedge clk0); #1;
      req_valid = 1'b1; req_cmd = RD; req_addr = 24'h0; req_len = 3'd0;
      bus_grant = ~GMASK;
      @(posedge clk0); #1;
      req_valid = 1'b0;
      ek = -1; tb_beats = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk0);
         if (mst_cmd != NOP) tb_beats++;
         if (err) begin
            ek = k;
            break;
         end
         @(posedge clk0); #1;
      end
      chk("to_lat", 128'(ek), 128'(TO));
      chk("to_beats", 128'(tb_beats), 128'(0));
      chk("to_state", 128'({req_ready, bus_request}), 128'({1'b1, 3'b000}));
      @(posedge clk0); #1;
      bus_grant = '0;
      @(negedge clk0);
      chk("to_pulse", 128'(err), 128'(0));

      // Reset while the last two read beats are still in flight.
      rt = '{RD, 24'h000400, 3'd3, 0, -1, 0, 0, 0, 0};
      run_txn(rt, 5, left);
      chk("rsp_left_at_rst", 128'(left), 128'(2));
      @(posedge clk0); #1;
      reset = 1'b0;
      dn = 0; rv = 0;
      repeat (12) begin
         @(negedge clk0);
         dn += int'(done | err);
         rv += int'(rsp_valid);
      end
      chk("post_rst_done", 128'(dn), 128'(0));
      chk("post_rst_rsp", 128'(rv), 128'(0));
      chk("post_rst_rdy", 128'(req_ready), 128'(1));

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
